// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder: FSM states, word width,
// and block geometry.
package mem_pkg;

  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } memState_t;

  function automatic int wordsPerBlock(input int returnSize);
    return returnSize / WORD_SIZE;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word store with a block-wide port. Writes are synchronous; the block read is
// combinational off the aligned address. MEM_INIT_EN: reset loads word a with a.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_LENGTH = 11,
  parameter int RETURN_SIZE = 128
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wrEn,
  input  logic [ADDR_LENGTH-1:0] blkAddr,
  input  logic [RETURN_SIZE-1:0] wrData,
  output logic [RETURN_SIZE-1:0] rdData
);

  localparam int WPB   = wordsPerBlock(RETURN_SIZE);
  localparam int DEPTH = 2 ** ADDR_LENGTH;

  logic [WORD_SIZE-1:0] store [DEPTH];

`ifdef MEM_INIT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int a = 0; a < DEPTH; a++) store[ADDR_LENGTH'(a)] <= WORD_SIZE'(a);
    end else if (wrEn) begin
      for (int w = 0; w < WPB; w++)
        store[blkAddr + ADDR_LENGTH'(w)] <= wrData[w*WORD_SIZE +: WORD_SIZE];
    end
  end
`else
  // Reset still blocks a write landing on the same edge.
  always_ff @(posedge clock) begin
    if (reset && wrEn) begin
      for (int w = 0; w < WPB; w++)
        store[blkAddr + ADDR_LENGTH'(w)] <= wrData[w*WORD_SIZE +: WORD_SIZE];
    end
  end
`endif

  for (genvar w = 0; w < WPB; w++) begin : gRd
    assign rdData[w*WORD_SIZE +: WORD_SIZE] = store[blkAddr + ADDR_LENGTH'(w)];
  end

endmodule

// File: rtl/mem_responder.sv
// Bottom-of-hierarchy block responder: latches a request, waits MEM_DELAY
// cycles, then reads or writes one block. Optional MEM_INIT_EN preloads the store.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_LENGTH = 11,
  parameter int RETURN_SIZE = 128,
  parameter int MEM_DELAY   = 20
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_LENGTH-1:0] addrIn,
  output logic [RETURN_SIZE-1:0] dataUpOut,
  input  logic [RETURN_SIZE-1:0] dataUpIn,
  output logic                   fetchComplete,
  input  logic                   enableIn,
  output logic                   writeCompleteOut,
  input  logic                   writeIn
);

  localparam int WPB   = wordsPerBlock(RETURN_SIZE);
  localparam int CNT_W = (MEM_DELAY < 2) ? 1 : $clog2(MEM_DELAY);
  localparam logic [ADDR_LENGTH-1:0] ALIGN_MASK = ~ADDR_LENGTH'(WPB - 1);
  localparam logic [CNT_W-1:0]       LAST_CNT   = CNT_W'(MEM_DELAY - 1);

  memState_t              state, nextState;
  logic [CNT_W-1:0]       count;
  logic [ADDR_LENGTH-1:0] reqAddr;
  logic                   reqWrite;
  logic [RETURN_SIZE-1:0] reqData;
  logic [RETURN_SIZE-1:0] rdBlock;
  logic                   accessEn, memWrEn, readLoad;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (enableIn) nextState = BUSY;
      BUSY: begin
        if (!enableIn)              nextState = IDLE;
        else if (count == LAST_CNT) nextState = DONE;
      end
      DONE: if (!enableIn) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Completion flags come straight from DONE, so they drop on the same edge
  // that returns the FSM to IDLE and can never both be high.
  always_comb begin
    accessEn         = (state == BUSY) && enableIn && (count == LAST_CNT);
    memWrEn          = accessEn && reqWrite;
    readLoad         = accessEn && !reqWrite;
    fetchComplete    = (state == DONE) && !reqWrite;
    writeCompleteOut = (state == DONE) && reqWrite;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count     <= '0;
      reqAddr   <= '0;
      reqWrite  <= 1'b0;
      reqData   <= '0;
      dataUpOut <= '0;
    end else begin
      if (state == IDLE && enableIn) begin
        count    <= '0;
        reqAddr  <= addrIn & ALIGN_MASK;
        reqWrite <= writeIn;
        if (writeIn) reqData <= dataUpIn;
      end else if (state == BUSY) begin
        count <= count + 1'b1;
      end
      if (readLoad) dataUpOut <= rdBlock;
    end
  end

  mem_array #(
    .ADDR_LENGTH(ADDR_LENGTH),
    .RETURN_SIZE(RETURN_SIZE)
  ) uArray (
    .clock  (clock),
    .reset  (reset),
    .wrEn   (memWrEn),
    .blkAddr(reqAddr),
    .wrData (reqData),
    .rdData (rdBlock)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency, read/write data, abort, hold,
// reset mid-request and top-of-store addressing.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int AL = 11;
  localparam int RS = 128;
  localparam int MD = 20;

  logic          clock, reset;
  logic [AL-1:0] addrIn;
  logic [RS-1:0] dataUpOut, dataUpIn;
  logic          fetchComplete, enableIn, writeCompleteOut, writeIn;

  int total = 0;
  int bad   = 0;

  mem_responder #(.ADDR_LENGTH(AL), .RETURN_SIZE(RS), .MEM_DELAY(MD)) dut (
    .clock           (clock),
    .reset           (reset),
    .addrIn          (addrIn),
    .dataUpOut       (dataUpOut),
    .dataUpIn        (dataUpIn),
    .fetchComplete   (fetchComplete),
    .enableIn        (enableIn),
    .writeCompleteOut(writeCompleteOut),
    .writeIn         (writeIn)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [RS-1:0] got, input logic [RS-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full request. lat = edges after the enable-sampling edge until the
  // completion flag is seen (-1 on timeout). Inputs are scrambled after the
  // latch edge so the DUT must use its latched copy.
  task automatic req(input logic [AL-1:0] a, input logic wr, input logic [RS-1:0] d,
                     input int hold, output int lat, output logic [RS-1:0] rd);
    logic other, held;
    other = 1'b0; held = 1'b1; lat = -1;
    @(negedge clock);
    addrIn = a; writeIn = wr; dataUpIn = d; enableIn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (i == 0) begin addrIn = ~a; writeIn = ~wr; dataUpIn = ~d; end
      if (wr ? fetchComplete : writeCompleteOut) other = 1'b1;
      if (wr ? writeCompleteOut : fetchComplete) begin lat = i; break; end
    end
    rd = dataUpOut;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      if (!(wr ? writeCompleteOut : fetchComplete)) held = 1'b0;
      if (wr ? fetchComplete : writeCompleteOut) other = 1'b1;
    end
    @(negedge clock);
    enableIn = 1'b0;
    @(posedge clock); #1;
    chk("otherFlag", RS'(other), '0);
    if (hold > 0) chk("holdHigh", RS'(held), RS'(1));
    chk("flagClear", RS'({fetchComplete, writeCompleteOut}), '0);
  endtask

  int lat;
  logic [RS-1:0] rd;
  logic sawFlag;

  initial begin
    reset = 1'b0; enableIn = 1'b0; writeIn = 1'b0; addrIn = '0; dataUpIn = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rstFetch", RS'(fetchComplete), '0);
    chk("rstWrite", RS'(writeCompleteOut), '0);
    chk("rstData", dataUpOut, '0);
    chk("rstState", RS'(dut.state), RS'(IDLE));
    @(negedge clock); reset = 1'b1;

    // Preload blocks with their own word addresses so the bench does not
    // depend on the init-on-reset option.
    req(11'h004, 1'b1, {32'h7, 32'h6, 32'h5, 32'h4}, 0, lat, rd);
    chk("preWrLat", RS'(lat), RS'(MD));
    req(11'h020, 1'b1, {32'h23, 32'h22, 32'h21, 32'h20}, 0, lat, rd);
    req(11'h040, 1'b1, {32'h43, 32'h42, 32'h41, 32'h40}, 0, lat, rd);
    req(11'h7FC, 1'b1, {32'h7FF, 32'h7FE, 32'h7FD, 32'h7FC}, 0, lat, rd);

    req(11'h005, 1'b0, '0, 0, lat, rd);
    chk("rd005Lat", RS'(lat), RS'(MD));
    chk("rd005Data", rd, {32'h7, 32'h6, 32'h5, 32'h4});

    req(11'h010, 1'b1, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 0, lat, rd);
    chk("wr010Lat", RS'(lat), RS'(MD));
    req(11'h012, 1'b0, '0, 0, lat, rd);
    chk("rd012Data", rd, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);

    // Abort a write after 5 busy cycles.
    sawFlag = 1'b0;
    @(negedge clock);
    addrIn = 11'h020; writeIn = 1'b1; dataUpIn = {4{32'h5555AAAA}}; enableIn = 1'b1;
    @(posedge clock);
    repeat (5) begin
      @(posedge clock); #1;
      if (fetchComplete || writeCompleteOut) sawFlag = 1'b1;
    end
    @(negedge clock); enableIn = 1'b0;
    @(posedge clock); #1;
    chk("abortState", RS'(dut.state), RS'(IDLE));
    chk("abortNoFlag", RS'(sawFlag | fetchComplete | writeCompleteOut), '0);
    req(11'h020, 1'b0, '0, 0, lat, rd);
    chk("rd020Data", rd, {32'h23, 32'h22, 32'h21, 32'h20});

    // Hold enable past completion, then re-request immediately.
    req(11'h004, 1'b0, '0, 10, lat, rd);
    chk("holdLat", RS'(lat), RS'(MD));
    req(11'h006, 1'b0, '0, 0, lat, rd);
    chk("reReqLat", RS'(lat), RS'(MD));
    chk("reReqData", rd, {32'h7, 32'h6, 32'h5, 32'h4});

    // Reset at count=10 of a write to 0x040.
    @(negedge clock);
    addrIn = 11'h040; writeIn = 1'b1; dataUpIn = {4{32'hFFFF0000}}; enableIn = 1'b1;
    @(posedge clock);
    repeat (10) @(posedge clock);
    #1;
    chk("midCount", RS'(dut.count), RS'(10));
    @(negedge clock); reset = 1'b0; enableIn = 1'b0;
    @(posedge clock); #1;
    chk("midRstFetch", RS'(fetchComplete), '0);
    chk("midRstWrite", RS'(writeCompleteOut), '0);
    chk("midRstData", dataUpOut, '0);
    chk("midRstState", RS'(dut.state), RS'(IDLE));
    @(negedge clock); reset = 1'b1;
    req(11'h040, 1'b0, '0, 0, lat, rd);
    chk("rd040Data", rd, {32'h43, 32'h42, 32'h41, 32'h40});

    req(11'h7FF, 1'b0, '0, 0, lat, rd);
    chk("rd7FFLat", RS'(lat), RS'(MD));
    chk("rd7FFData", rd, {32'h7FF, 32'h7FE, 32'h7FD, 32'h7FC});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
